// File: rtl/uart_responder_if.sv
// Controller-side strobes and status lines of the serial-port responder.
interface uart_responder_if;
  logic rdn;
  logic wrn;
  logic data_ready;
  logic tbre;
  logic tsre;
  logic rx_overrun;

  modport master (
    output rdn,
    output wrn,
    input  data_ready,
    input  tbre,
    input  tsre,
    input  rx_overrun
  );

  modport slave (
    input  rdn,
    input  wrn,
    output data_ready,
    output tbre,
    output tsre,
    output rx_overrun
  );
endinterface

// File: rtl/uart_responder.sv
// Bus responder with THR/RBR registers and an 8N1 serial transmitter and receiver.
// Strobe edges compare the pin against last cycle's sample.
module uart_responder #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic            clk_50MHz,
  input  logic            rst,
  uart_responder_if.slave bus,
  inout  wire  [15:0]     ram1_data,
  output logic            txd,
  input  logic            rxd
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Strobe samples
  logic rdn_q, wrn_q;
  logic wr_fall, rd_rise;

  // Transmit path
  state_e          tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      thr_q, thr_d;
  logic [7:0]      tsr_q, tsr_d;
  logic            tbre_q, tbre_d;
  logic            tsre_q, tsre_d;
  logic            tx_load;

  // Receive path
  logic            rx_sync1_q, rx_sync2_q, rx_prev_q;
  state_e          rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rbr_q, rbr_d;
  logic            data_ready_q, data_ready_d;
  logic            overrun_q, overrun_d;
  logic            rx_commit;

  // A simultaneous read owns the bus, so the write edge is qualified by rdn.
  assign wr_fall = wrn_q & ~bus.wrn & bus.rdn;
  assign rd_rise = ~rdn_q & bus.rdn;

  assign ram1_data      = (!bus.rdn) ? {8'h00, rbr_q} : 16'hzzzz;
  assign bus.data_ready = data_ready_q;
  assign bus.tbre       = tbre_q;
  assign bus.tsre       = tsre_q;
  assign bus.rx_overrun = overrun_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    thr_d      = thr_q;
    tsr_d      = tsr_q;
    tbre_d     = tbre_q;
    tsre_d     = tsre_q;
    tx_load    = 1'b0;
    txd        = 1'b1;

    if (wr_fall && tbre_q) begin
      thr_d  = ram1_data[7:0];
      tbre_d = 1'b0;
    end

    unique case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        tx_load  = ~tbre_q;
      end
      StStart: begin
        txd = 1'b0;
        if (tx_cnt_q == CntLast) begin
          tx_state_d = StData;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end
      end
      StData: begin
        txd = tsr_q[tx_bit_q];
        if (tx_cnt_q == CntLast) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = StStop;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (tx_cnt_q == CntLast) begin
          if (!tbre_q) begin
            tx_load = 1'b1;
          end else begin
            tsre_d     = 1'b1;
            tx_state_d = StIdle;
            tx_cnt_d   = '0;
          end
        end
      end
      default: tx_state_d = StIdle;
    endcase

    // A pending THR byte follows the stop bit with no idle gap.
    if (tx_load) begin
      tsr_d      = thr_q;
      tbre_d     = 1'b1;
      tsre_d     = 1'b0;
      tx_state_d = StStart;
      tx_cnt_d   = '0;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + 1'b1;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rbr_d        = rbr_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    rx_commit    = 1'b0;

    unique case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d = StStart;
        end
      end
      StStart: begin
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync2_q ? StIdle : StData;
        end
      end
      StData: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = StStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (rx_cnt_q == CntLast) begin
          rx_cnt_d   = '0;
          rx_state_d = StIdle;
          rx_commit  = rx_sync2_q;
        end
      end
      default: rx_state_d = StIdle;
    endcase

    if (rd_rise) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end
    // A commit beats a same-cycle read release; the released byte counts as read.
    if (rx_commit) begin
      rbr_d        = rx_shift_q;
      data_ready_d = 1'b1;
      if (data_ready_q && !rd_rise) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      rdn_q        <= 1'b1;
      wrn_q        <= 1'b1;
      tx_state_q   <= StIdle;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      thr_q        <= 8'h00;
      tsr_q        <= 8'h00;
      tbre_q       <= 1'b1;
      tsre_q       <= 1'b1;
      rx_sync1_q   <= 1'b1;
      rx_sync2_q   <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= StIdle;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= 8'h00;
      rbr_q        <= 8'h00;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rdn_q        <= bus.rdn;
      wrn_q        <= bus.wrn;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      thr_q        <= thr_d;
      tsr_q        <= tsr_d;
      tbre_q       <= tbre_d;
      tsre_q       <= tsre_d;
      rx_sync1_q   <= rxd;
      rx_sync2_q   <= rx_sync1_q;
      rx_prev_q    <= rx_sync2_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rbr_q        <= rbr_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_responder.sv
// Randomised bench for uart_responder; a frame/flag model predicts txd frames, status and RBR.
module tb_uart_responder;

  localparam int unsigned Cpb      = 4;
  localparam int          FrameCyc = 10 * Cpb;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        txd;
  logic        tb_drv;
  logic [15:0] tb_wdata;
  wire  [15:0] ram1_data;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  uart_responder_if u_if ();

  // The bus floats high whenever neither side drives it.
  assign ram1_data = tb_drv ? tb_wdata : 16'hzzzz;
  pullup pu_bus (ram1_data);

  uart_responder #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk_50MHz(clk),
    .rst      (rst),
    .bus      (u_if),
    .ram1_data(ram1_data),
    .txd      (txd),
    .rxd      (rxd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Model: TX timing from plain cycle arithmetic, RX as flags plus a byte register.
  int          thr_empty_at = -1;
  int          tx_free_at   = 0;
  int          tx_exp_b[$];
  int          tx_exp_s[$];
  logic [7:0]  m_rbr;
  bit          m_dr;
  bit          m_ovr;

  function automatic logic [63:0] frame_bits(input logic [7:0] b);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < FrameCyc; i++) begin
      int k;
      k = i / Cpb;
      v[i] = (k == 0) ? 1'b0 : ((k == 9) ? 1'b1 : b[k-1]);
    end
    return v;
  endfunction

  // Serial monitor: captures each frame cycle by cycle and checks it against the model queue.
  int          mon_n = 0;
  int          mon_start = 0;
  logic [63:0] mon_vec;

  always @(negedge clk) begin
    if (!rst) begin
      mon_n = 0;
    end else if (mon_n == 0) begin
      if (txd == 1'b0) begin
        mon_vec    = '0;
        mon_start  = cyc;
        mon_n      = 1;
      end
    end else begin
      mon_vec[mon_n] = txd;
      mon_n++;
      if (mon_n == FrameCyc) begin
        mon_n = 0;
        check_eq("tx_frame_expected", 64'(tx_exp_b.size() > 0), 64'(1));
        if (tx_exp_b.size() > 0) begin
          check_eq("tx_frame", mon_vec, frame_bits(8'(tx_exp_b.pop_front())));
          check_eq("tx_start_cycle", 64'(mon_start), 64'(tx_exp_s.pop_front()));
        end
      end
    end
  end

  task automatic wr(input logic [15:0] w);
    int n;
    int start;
    bit acc;
    @(negedge clk);
    tb_wdata   = w;
    tb_drv     = 1'b1;
    u_if.wrn   = 1'b0;
    @(negedge clk);
    n   = cyc;
    acc = (thr_empty_at < n);
    if (acc) begin
      start        = (tx_free_at > n + 1) ? tx_free_at : n + 1;
      thr_empty_at = start;
      tx_free_at   = start + FrameCyc;
      tx_exp_b.push_back(int'(w[7:0]));
      tx_exp_s.push_back(start);
    end
    check_eq("tbre_after_write", 64'(u_if.tbre), 64'(acc ? 1'b0 : (thr_empty_at <= n)));
    u_if.wrn = 1'b1;
    tb_drv   = 1'b0;
  endtask

  task automatic wait_tx_idle();
    while (cyc < tx_free_at + 1) @(negedge clk);
    check_eq("tx_all_frames_seen", 64'(tx_exp_b.size()), 64'(0));
    check_eq("tsre_idle", 64'(u_if.tsre), 64'(1));
  endtask

  task automatic rd();
    @(negedge clk);
    #1 check_eq("bus_released_before_read", 64'(ram1_data), 64'(16'hFFFF));
    u_if.rdn = 1'b0;
    #1 check_eq("read_data", 64'(ram1_data), 64'({8'h00, m_rbr}));
    @(negedge clk);
    u_if.rdn = 1'b1;
    #1 check_eq("bus_released_after_read", 64'(ram1_data), 64'(16'hFFFF));
    @(negedge clk);
    m_dr  = 1'b0;
    m_ovr = 1'b0;
    check_eq("data_ready_after_read", 64'(u_if.data_ready), 64'(m_dr));
    check_eq("overrun_after_read", 64'(u_if.rx_overrun), 64'(m_ovr));
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, output int f0);
    logic [9:0] f;
    f  = {stop, b, 1'b0};
    f0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) f0 = cyc;
      rxd = f[i];
      repeat (Cpb - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input bit measure);
    int f0;
    int lat;
    send_frame(b, stop, f0);
    if (stop) begin
      m_ovr = m_ovr | m_dr;
      m_dr  = 1'b1;
      m_rbr = b;
    end
    if (measure) begin
      lat = -1;
      for (int i = 0; i < 8 && lat < 0; i++) begin
        @(negedge clk);
        if (u_if.data_ready) lat = cyc - f0;
      end
      // Nominal 2 + 9.5 bit times after the falling edge, +/-1 cycle.
      check_eq("rx_latency_in_window", 64'(lat >= 39 && lat <= 41), 64'(1));
    end else begin
      repeat (4) @(negedge clk);
    end
    check_eq("data_ready", 64'(u_if.data_ready), 64'(m_dr));
    check_eq("rx_overrun", 64'(u_if.rx_overrun), 64'(m_ovr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed still running, required finished (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    logic [7:0] b;
    rst      = 1'b0;
    rxd      = 1'b1;
    tb_drv   = 1'b0;
    tb_wdata = 16'h0000;
    u_if.rdn = 1'b1;
    u_if.wrn = 1'b1;
    m_rbr    = 8'h00;
    m_dr     = 1'b0;
    m_ovr    = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("reset_txd", 64'(txd), 64'(1));
    check_eq("reset_tbre", 64'(u_if.tbre), 64'(1));
    check_eq("reset_tsre", 64'(u_if.tsre), 64'(1));
    check_eq("reset_data_ready", 64'(u_if.data_ready), 64'(0));
    check_eq("reset_overrun", 64'(u_if.rx_overrun), 64'(0));
    check_eq("reset_bus_released", 64'(ram1_data), 64'(16'hFFFF));
    rst = 1'b1;

    // Single transmit: tbre low one cycle, start bit on the next edge, tsre low 40 cycles.
    wr(16'h1255);
    @(negedge clk);
    check_eq("tbre_after_load", 64'(u_if.tbre), 64'(1));
    check_eq("tsre_after_load", 64'(u_if.tsre), 64'(0));
    check_eq("txd_start_bit", 64'(txd), 64'(0));
    while (cyc < tx_free_at - 1) @(negedge clk);
    check_eq("tsre_last_stop_cycle", 64'(u_if.tsre), 64'(0));
    @(negedge clk);
    check_eq("tsre_after_frame", 64'(u_if.tsre), 64'(1));
    wait_tx_idle();

    // Back-to-back frames; the third write lands while THR is full and is dropped.
    wr({8'hA0, 8'h0F});
    repeat (5) @(negedge clk);
    wr({8'h3C, 8'hF0});
    repeat (2) @(negedge clk);
    wr({8'h77, 8'h99});
    wait_tx_idle();

    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 45)) @(negedge clk);
      wr({8'($urandom), 8'($urandom)});
    end
    wait_tx_idle();

    rx_frame(8'hA5, 1'b1, 1'b1);
    rd();

    rx_frame(8'h11, 1'b1, 1'b1);
    rx_frame(8'h22, 1'b1, 1'b0);
    rd();

    rx_frame(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (50) @(negedge clk);
    check_eq("glitch_no_byte", 64'(u_if.data_ready), 64'(m_dr));

    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      rx_frame(b, 1'b1, 1'b1);
      rd();
    end

    // Reset during data bit 3 of 8'hB7 (bit 3 is 0, so txd must visibly jump high).
    wr({8'h00, 8'hB7});
    s = thr_empty_at;
    while (cyc < s + Cpb + 3 * Cpb + 1) @(negedge clk);
    check_eq("tx_bit3_before_reset", 64'(txd), 64'(0));
    #2 rst = 1'b0;
    tx_exp_b.delete();
    tx_exp_s.delete();
    thr_empty_at = -1;
    tx_free_at   = 0;
    m_rbr        = 8'h00;
    m_dr         = 1'b0;
    m_ovr        = 1'b0;
    #1;
    check_eq("midreset_txd", 64'(txd), 64'(1));
    check_eq("midreset_tbre", 64'(u_if.tbre), 64'(1));
    check_eq("midreset_tsre", 64'(u_if.tsre), 64'(1));
    @(negedge clk);
    #2 rst = 1'b1;
    rd();
    wr({8'h5E, 8'hC3});
    @(negedge clk);
    check_eq("post_reset_start_bit", 64'(txd), 64'(0));
    wait_tx_idle();

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_responder.md
# uart_responder

Bus-side responder for the CPU's serial-port interface: it answers the `rdn`/`wrn` strobes and drives the `data_ready`/`tbre`/`tsre` status lines that the memory/IO controller uses at address 0xBF01. It also runs a byte-wide 8N1 serial transmitter and receiver. It shares the low byte of the RAM1 data bus with SRAM1 and replaces the discrete UART chip in simulation and FPGA-only builds.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range is 4 or more.
- `clk_50MHz`  in  1  system clock. All logic runs on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ram1_data`  inout  16  shared RAM1 data bus. The block drives it only while reading; otherwise it is high-Z.
- `rdn`  in  1  active-low read strobe from the controller.
- `wrn`  in  1  active-low write strobe from the controller.
- `data_ready`  out  1  the receive buffer register (RBR) holds an unread byte.
- `tbre`  out  1  the transmit holding register (THR) is empty.
- `tsre`  out  1  the transmit shift register (TSR) is idle.
- `txd`  out  1  serial output, idle high.
- `rxd`  in  1  serial input. It is asynchronous to the clock and is synchronised internally.
- `rx_overrun`  out  1  sticky flag: an unread byte was overwritten.

## Operation
- **Reset values:**
  - `txd`=1, `tbre`=1, `tsre`=1, `data_ready`=0, `rx_overrun`=0.
  - RBR=THR=8'h00.
  - `ram1_data`=Z.
  - Both FSMs are in IDLE.
- **Strobe sampling:** `rdn` and `wrn` are registered each cycle. An edge is a difference between the current sample and the previous one.
- **Write:**
  - Trigger: the `wrn` sample goes 1→0 while `rdn`=1.
  - If `tbre`=1, THR <= `ram1_data[7:0]` and `tbre` becomes 0.
  - If `tbre`=0, the write is ignored.
  - `ram1_data[15:8]` is ignored.
- **Read:**
  - While `rdn`=0 (combinational on the pin), the block drives `ram1_data` = {8'h00, RBR}.
  - When the `rdn` sample goes 0→1, `data_ready` and `rx_overrun` clear.
- **Both strobes low together:** the read drives the bus and the write edge is ignored.
- **TX FSM, states IDLE → START → DATA → STOP → IDLE:**
  - In IDLE with `tbre`=0: TSR <= THR, `tbre` becomes 1, `tsre` becomes 0, and the FSM enters START.
  - START drives `txd`=0 for `CLKS_PER_BIT` cycles.
  - DATA sends 8 bits LSB first, `CLKS_PER_BIT` cycles each. A 3-bit counter tracks the bit index.
  - STOP drives `txd`=1 for `CLKS_PER_BIT` cycles.
  - At the end of STOP, if `tbre`=0 the FSM reloads immediately into START with no idle gap. Otherwise `tsre` becomes 1 and the FSM returns to IDLE.
- **RX FSM, states IDLE → START → DATA → STOP:**
  - `rxd` passes through a 2-FF synchroniser.
  - IDLE waits for a synchronised 1→0 transition.
  - START re-samples at `CLKS_PER_BIT/2`. If the line is high, the start was a glitch and the FSM returns to IDLE.
  - DATA samples at mid-bit, 8 times, LSB first, into a shift register.
  - STOP samples at mid-bit:
    - If the sample is 1: RBR <= shift register and `data_ready` becomes 1. If `data_ready` was already 1, `rx_overrun` becomes 1.
    - If the sample is 0 (framing error): the byte is discarded and flags are unchanged.
  - In both cases the FSM returns to IDLE.
- **Simultaneous events:** if a byte commit and the `rdn` release edge fall on the same cycle, the commit wins. `data_ready` stays 1 and `rx_overrun` is not set.
- **Counters:** the baud counter is ceil(log2(`CLKS_PER_BIT`)) bits wide and counts 0..`CLKS_PER_BIT`-1, then wraps. It restarts on every state entry.

## Timing
- **Write to start bit:**
  - At edge N, the `wrn` falling sample loads THR; `tbre`=0 after N.
  - If TX was idle, edge N+1 gives `tbre`=1, `tsre`=0, `txd`=0.
- **TX frame:** exactly 10·`CLKS_PER_BIT` cycles. `tsre`=1 follows the last stop cycle.
- **Back-to-back writes:** a second write accepted while the TSR is busy starts its start bit on the cycle after the previous stop bit ends.
- **RX latency:** `data_ready` rises 2 (synchroniser) + 9.5·`CLKS_PER_BIT` ±1 cycles after the `rxd` falling edge.
- **Read data:** valid combinationally while `rdn`=0. `data_ready` falls one cycle after the `rdn` sample returns high.
- **Reset mid-operation:** asserting `rst` mid-frame forces the reset values immediately. Any frame in flight is aborted and `txd` returns high at once.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- **Single TX:** `wrn` pulse with `ram1_data`=16'h1255 → `txd` shows 0,1,0,1,0,1,0,1,0,1, 4 cycles per bit. `tbre` is low for 1 cycle and `tsre` is low for 40 cycles.
- **Back-to-back TX:** write 8'h0F, then write 8'hF0 while TX is busy, then write a third byte while `tbre`=0 → two contiguous frames are sent with no idle gap, and the third write is dropped.
- **RX and read:** drive an 8'hA5 frame on `rxd` → `data_ready`=1. A `rdn` pulse shows `ram1_data`=16'h00A5, and `data_ready`=0 one cycle after release. The bus is Z before and after the pulse.
- **Overrun:** send 8'h11 and then 8'h22 without reading → RBR=8'h22 and `rx_overrun`=1. Both flags clear after one read.
- **Error frames:**
  - A frame with the stop bit at 0 → `data_ready` stays 0.
  - A 1-cycle low glitch on `rxd` → no byte is received.
- **Reset mid-frame:** assert `rst` during TX bit 3 → `txd`=1, `tbre`=1, `tsre`=1 immediately. After release, a fresh write transmits correctly.
